// File: rtl/mem_arbiter_pkg.sv
// Shared parameters for the memory arbiter: bus widths, FSM encoding,
// access-size codes and transfer lengths.
package mem_arbiter_pkg;

    localparam int PC_LEN    = 32;
    localparam int INSTR_LEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IC_RD = 2'd1,
        ST_LS_RD = 2'd2,
        ST_LS_WR = 2'd3
    } arb_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [2:0] LEN_BYTE = 3'd1;
    localparam logic [2:0] LEN_HALF = 3'd2;
    localparam logic [2:0] LEN_WORD = 3'd4;
    localparam logic [2:0] LEN_IC   = 3'd4;

    function automatic logic [2:0] xfer_len(input logic [1:0] size);
        logic [2:0] len;
        case (size)
            SIZE_BYTE: len = LEN_BYTE;
            SIZE_HALF: len = LEN_HALF;
            default:   len = LEN_WORD;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store unit onto a
// byte-wide RAM port; multi-byte accesses are serialised little-endian.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_in,
    input  logic                 ic_req,
    input  logic [PC_LEN-1:0]    ic_addr,
    output logic                 ic_done,
    output logic [INSTR_LEN-1:0] ic_data,
    input  logic                 lsb_req,
    input  logic                 lsb_we,
    input  logic [PC_LEN-1:0]    lsb_addr,
    input  logic [1:0]           lsb_size,
    input  logic [INSTR_LEN-1:0] lsb_wdata,
    output logic                 lsb_done,
    output logic [INSTR_LEN-1:0] lsb_rdata,
    input  logic [7:0]           mem_din,
    output logic [7:0]           mem_dout,
    output logic [PC_LEN-1:0]    mem_a,
    output logic                 mem_wr
);

    arb_state_e           state_r;
    logic [2:0]           cnt_r;
    logic [2:0]           len_r;
    logic                 last_lsb_r;
    logic [PC_LEN-1:0]    base_r;
    logic [INSTR_LEN-1:0] wdata_r;
    logic [INSTR_LEN-1:0] rd_buf_r;

    logic                 ic_ok_s;
    logic                 lsb_ok_s;
    logic                 grant_ic_s;
    logic                 grant_lsb_s;
    logic [2:0]           next_idx_s;
    logic [2:0]           byte_sel_s;
    logic [PC_LEN-1:0]    next_addr_s;
    logic [INSTR_LEN-1:0] rd_merge_s;

    // Request qualification, round-robin grant and next-byte datapath
    always_comb begin
        ic_ok_s     = ic_req && !ic_done && !flush_in;
        lsb_ok_s    = lsb_req && !lsb_done && !flush_in;
        grant_ic_s  = 1'b0;
        grant_lsb_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (ic_ok_s && lsb_ok_s) begin
                grant_lsb_s = !last_lsb_r;
                grant_ic_s  = last_lsb_r;
            end else begin
                grant_ic_s  = ic_ok_s;
                grant_lsb_s = lsb_ok_s;
            end
        end else begin
            grant_ic_s  = 1'b0;
            grant_lsb_s = 1'b0;
        end
        next_idx_s  = cnt_r + 3'd1;
        next_addr_s = base_r + PC_LEN'(next_idx_s);
        // Read data lags its address by one cycle, so count k carries byte k-1
        byte_sel_s  = cnt_r - 3'd1;
        rd_merge_s  = rd_buf_r | (INSTR_LEN'(mem_din) << {byte_sel_s[1:0], 3'b000});
    end

    // Transfer FSM with registered RAM-side and requester-side outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 3'd0;
            len_r      <= 3'd0;
            last_lsb_r <= 1'b0;
            base_r     <= '0;
            wdata_r    <= '0;
            rd_buf_r   <= '0;
            ic_done    <= 1'b0;
            ic_data    <= '0;
            lsb_done   <= 1'b0;
            lsb_rdata  <= '0;
            mem_dout   <= 8'd0;
            mem_a      <= '0;
            mem_wr     <= 1'b0;
        end else begin
            ic_done  <= 1'b0;
            lsb_done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r    <= 3'd0;
                    mem_a    <= '0;
                    mem_wr   <= 1'b0;
                    mem_dout <= 8'd0;
                    if (grant_lsb_s) begin
                        last_lsb_r <= 1'b1;
                        base_r     <= lsb_addr;
                        len_r      <= xfer_len(lsb_size);
                        wdata_r    <= lsb_wdata;
                        rd_buf_r   <= '0;
                        mem_a      <= lsb_addr;
                        mem_wr     <= lsb_we;
                        mem_dout   <= lsb_we ? lsb_wdata[7:0] : 8'd0;
                        state_r    <= lsb_we ? ST_LS_WR : ST_LS_RD;
                    end else if (grant_ic_s) begin
                        last_lsb_r <= 1'b0;
                        base_r     <= ic_addr;
                        len_r      <= LEN_IC;
                        rd_buf_r   <= '0;
                        mem_a      <= ic_addr;
                        state_r    <= ST_IC_RD;
                    end
                end
                ST_IC_RD, ST_LS_RD: begin
                    if (flush_in) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 3'd0;
                        mem_a   <= '0;
                    end else begin
                        cnt_r <= next_idx_s;
                        mem_a <= (next_idx_s < len_r) ? next_addr_s : '0;
                        if (cnt_r != 3'd0) begin
                            rd_buf_r <= rd_merge_s;
                        end
                        if (cnt_r == len_r) begin
                            state_r <= ST_IDLE;
                            cnt_r   <= 3'd0;
                            if (state_r == ST_IC_RD) begin
                                ic_done <= 1'b1;
                                ic_data <= rd_merge_s;
                            end else begin
                                lsb_done  <= 1'b1;
                                lsb_rdata <= rd_merge_s;
                            end
                        end
                    end
                end
                ST_LS_WR: begin
                    // Stores are never aborted by a flush once started
                    if (next_idx_s == len_r) begin
                        state_r  <= ST_IDLE;
                        cnt_r    <= 3'd0;
                        mem_a    <= '0;
                        mem_wr   <= 1'b0;
                        mem_dout <= 8'd0;
                        lsb_done <= 1'b1;
                    end else begin
                        cnt_r    <= next_idx_s;
                        mem_a    <= next_addr_s;
                        mem_dout <= wdata_r[{next_idx_s[1:0], 3'b000} +: 8];
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 3'd0;
                    mem_a   <= '0;
                    mem_wr  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected done events are queued at
// stimulus time and matched as the DUT produces them; bus activity is logged.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int LOG_N = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_in = 1'b0;
    logic        ic_req = 1'b0;
    logic [31:0] ic_addr = 32'd0;
    logic        ic_done;
    logic [31:0] ic_data;
    logic        lsb_req = 1'b0;
    logic        lsb_we = 1'b0;
    logic [31:0] lsb_addr = 32'd0;
    logic [1:0]  lsb_size = 2'd0;
    logic [31:0] lsb_wdata = 32'd0;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .flush_in(flush_in),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
        .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_addr(lsb_addr), .lsb_size(lsb_size),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    typedef struct {
        string       name;
        bit          is_ic;
        int          cyc;
        bit          chk_data;
        logic [31:0] data;
    } done_t;

    done_t       exp_q[$];
    logic [7:0]  ram [0:65535];
    logic [31:0] a_log [0:LOG_N-1];
    logic        wr_log [0:LOG_N-1];
    logic [7:0]  d_log [0:LOG_N-1];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          both_cnt = 0;

    // RAM read port: data for an address appears one cycle later
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        mem_din <= ram[mem_a[15:0]];
    end

    // Bus logger and scoreboard consumer for done pulses
    always begin
        done_t       e;
        logic        obs_ic;
        logic [31:0] obs_data;
        @(negedge clk);
        if (cyc < LOG_N) begin
            a_log[cyc]  = mem_a;
            wr_log[cyc] = mem_wr;
            d_log[cyc]  = mem_dout;
        end
        if (ic_done && lsb_done) both_cnt++;
        if (ic_done || lsb_done) begin
            obs_ic   = ic_done;
            obs_data = ic_done ? ic_data : lsb_rdata;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done cyc=%0d src_ic=%0b data=%h, expected no done", cyc, obs_ic, obs_data);
            end else begin
                e = exp_q.pop_front();
                if (e.is_ic !== obs_ic || e.cyc != cyc || (e.chk_data && obs_data !== e.data)) begin
                    errors++;
                    $display("FAIL sb_%s got src_ic=%0b cyc=%0d data=%h, expected src_ic=%0b cyc=%0d data=%h",
                             e.name, obs_ic, cyc, obs_data, e.is_ic, e.cyc, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sb();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++;
        if (mem_a !== 32'd0 || mem_wr !== 1'b0 || mem_dout !== 8'd0) begin
            errors++; $display("FAIL reset_bus got a=%h wr=%b d=%h, expected 0", mem_a, mem_wr, mem_dout);
        end
        checks++;
        if (ic_done !== 1'b0 || lsb_done !== 1'b0 || ic_data !== 32'd0 || lsb_rdata !== 32'd0) begin
            errors++; $display("FAIL reset_req_side got icd=%b lsd=%b icdata=%h lsdata=%h, expected 0",
                               ic_done, lsb_done, ic_data, lsb_rdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        tick();
    endtask

    task automatic test_ic_fetch();
        int t;
        ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05; ram[16'h1002] = 8'h10; ram[16'h1003] = 8'h00;
        repeat (2) tick();
        t = cyc; ic_req = 1'b1; ic_addr = 32'h0000_1000;
        exp_q.push_back('{"ic_fetch", 1'b1, t + 6, 1'b1, 32'h0010_0513});
        tick(); ic_req = 1'b0;
        wait_sb();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL ic_fetch_timeout pending=%0d, expected 0", exp_q.size()); exp_q.delete(); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (a_log[t+1+i] !== 32'h1000 + 32'(i) || wr_log[t+1+i] !== 1'b0) begin
                errors++; $display("FAIL ic_fetch_addr%0d got a=%h wr=%b, expected a=%h wr=0", i, a_log[t+1+i], wr_log[t+1+i], 32'h1000 + 32'(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        int t;
        repeat (2) tick();
        t = cyc; ic_req = 1'b1; ic_addr = 32'h0000_1000;
        exp_q.push_back('{"b2b_first", 1'b1, t + 6, 1'b1, 32'h0010_0513});
        exp_q.push_back('{"b2b_second", 1'b1, t + 13, 1'b1, 32'h0010_0513});
        repeat (8) tick();
        ic_req = 1'b0;
        wait_sb();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_timeout pending=%0d, expected 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (a_log[t+7] !== 32'd0 || a_log[t+8] !== 32'h1000) begin
            errors++; $display("FAIL b2b_regrant got a7=%h a8=%h, expected 0 and 1000", a_log[t+7], a_log[t+8]);
        end
    endtask

    task automatic test_tie_lsb_first();
        int t;
        ram[16'h2003] = 8'hFF;
        ram[16'h0000] = 8'h11; ram[16'h0001] = 8'h22; ram[16'h0002] = 8'h33; ram[16'h0003] = 8'h44;
        repeat (2) tick();
        t = cyc;
        lsb_req = 1'b1; lsb_we = 1'b0; lsb_size = 2'd0; lsb_addr = 32'h0000_2003;
        ic_req = 1'b1; ic_addr = 32'h0000_0000;
        exp_q.push_back('{"tie1_lsb", 1'b0, t + 3, 1'b1, 32'h0000_00FF});
        exp_q.push_back('{"tie1_ic", 1'b1, t + 9, 1'b1, 32'h4433_2211});
        tick(); lsb_req = 1'b0;
        repeat (3) tick();
        ic_req = 1'b0;
        wait_sb();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL tie1_timeout pending=%0d, expected 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (a_log[t+1] !== 32'h2003 || a_log[t+4] !== 32'h0) begin
            errors++; $display("FAIL tie1_bus got a1=%h a4=%h, expected 2003 and 0", a_log[t+1], a_log[t+4]);
        end
    endtask

    task automatic test_store_word();
        int t;
        logic [31:0] wd;
        wd = 32'hDEAD_BEEF;
        repeat (2) tick();
        t = cyc;
        lsb_req = 1'b1; lsb_we = 1'b1; lsb_size = 2'd2; lsb_addr = 32'h0000_3000; lsb_wdata = wd;
        exp_q.push_back('{"store_word", 1'b0, t + 5, 1'b0, 32'd0});
        tick(); lsb_req = 1'b0; lsb_we = 1'b0;
        wait_sb();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL store_timeout pending=%0d, expected 0", exp_q.size()); exp_q.delete(); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (a_log[t+1+i] !== 32'h3000 + 32'(i) || wr_log[t+1+i] !== 1'b1 || d_log[t+1+i] !== wd[8*i +: 8]) begin
                errors++; $display("FAIL store_byte%0d got a=%h wr=%b d=%h, expected a=%h wr=1 d=%h",
                                   i, a_log[t+1+i], wr_log[t+1+i], d_log[t+1+i], 32'h3000 + 32'(i), wd[8*i +: 8]);
            end
        end
        checks++;
        if (wr_log[t+5] !== 1'b0) begin errors++; $display("FAIL store_wr_end got %b, expected 0", wr_log[t+5]); end
    endtask

    task automatic test_tie_ic_first();
        int t;
        ram[16'h2000] = 8'hA1; ram[16'h2001] = 8'hB2; ram[16'h2002] = 8'hC3;
        ram[16'h0000] = 8'h00;
        repeat (2) tick();
        t = cyc;
        ic_req = 1'b1; ic_addr = 32'h0000_1000;
        lsb_req = 1'b1; lsb_we = 1'b0; lsb_size = 2'd2; lsb_addr = 32'h0000_2000;
        exp_q.push_back('{"tie2_ic", 1'b1, t + 6, 1'b1, 32'h0010_0513});
        exp_q.push_back('{"tie2_lsb", 1'b0, t + 12, 1'b1, 32'hFFC3_B2A1});
        tick(); ic_req = 1'b0;
        repeat (6) tick();
        lsb_req = 1'b0;
        wait_sb();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL tie2_timeout pending=%0d, expected 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (a_log[t+1] !== 32'h1000 || a_log[t+7] !== 32'h2000) begin
            errors++; $display("FAIL tie2_bus got a1=%h a7=%h, expected 1000 and 2000", a_log[t+1], a_log[t+7]);
        end
    endtask

    task automatic test_wrap_half_load();
        int t;
        ram[16'hFFFF] = 8'h34; ram[16'h0000] = 8'h12;
        repeat (2) tick();
        t = cyc;
        lsb_req = 1'b1; lsb_we = 1'b0; lsb_size = 2'd1; lsb_addr = 32'hFFFF_FFFF;
        exp_q.push_back('{"wrap_half", 1'b0, t + 4, 1'b1, 32'h0000_1234});
        tick(); lsb_req = 1'b0;
        wait_sb();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_timeout pending=%0d, expected 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (a_log[t+1] !== 32'hFFFF_FFFF || a_log[t+2] !== 32'h0) begin
            errors++; $display("FAIL wrap_addr got a1=%h a2=%h, expected ffffffff and 0", a_log[t+1], a_log[t+2]);
        end
    endtask

    task automatic test_flush_ic();
        int t;
        ram[16'h1000] = 8'h13;
        repeat (2) tick();
        t = cyc; ic_req = 1'b1; ic_addr = 32'h0000_1000;
        tick(); ic_req = 1'b0;
        tick(); flush_in = 1'b1;
        tick(); flush_in = 1'b0; ic_req = 1'b1;
        exp_q.push_back('{"flush_ic_refetch", 1'b1, t + 9, 1'b1, 32'h0010_0513});
        tick(); ic_req = 1'b0;
        wait_sb();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL flush_ic_timeout pending=%0d, expected 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (wr_log[t+1] !== 1'b0 || wr_log[t+2] !== 1'b0 || wr_log[t+3] !== 1'b0 || a_log[t+3] !== 32'h0) begin
            errors++; $display("FAIL flush_ic_idle got wr=%b%b%b a3=%h, expected wr=000 a3=0",
                               wr_log[t+1], wr_log[t+2], wr_log[t+3], a_log[t+3]);
        end
        checks++;
        if (a_log[t+4] !== 32'h1000) begin errors++; $display("FAIL flush_ic_regrant got a4=%h, expected 1000", a_log[t+4]); end
    endtask

    task automatic test_flush_store();
        int t;
        repeat (2) tick();
        t = cyc;
        lsb_req = 1'b1; lsb_we = 1'b1; lsb_size = 2'd1; lsb_addr = 32'h0000_3100; lsb_wdata = 32'h1234_CAFE;
        exp_q.push_back('{"flush_store", 1'b0, t + 3, 1'b0, 32'd0});
        tick(); lsb_req = 1'b0; lsb_we = 1'b0;
        tick(); flush_in = 1'b1;
        tick();
        tick(); flush_in = 1'b0;
        wait_sb();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL flush_store_timeout pending=%0d, expected 0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (a_log[t+1] !== 32'h3100 || wr_log[t+1] !== 1'b1 || d_log[t+1] !== 8'hFE ||
            a_log[t+2] !== 32'h3101 || wr_log[t+2] !== 1'b1 || d_log[t+2] !== 8'hCA || wr_log[t+3] !== 1'b0) begin
            errors++; $display("FAIL flush_store_bus got %h/%b/%h %h/%b/%h wr3=%b, expected 3100/1/fe 3101/1/ca wr3=0",
                               a_log[t+1], wr_log[t+1], d_log[t+1], a_log[t+2], wr_log[t+2], d_log[t+2], wr_log[t+3]);
        end
    endtask

    task automatic test_reset_mid_read();
        int t;
        repeat (2) tick();
        lsb_req = 1'b1; lsb_we = 1'b0; lsb_size = 2'd2; lsb_addr = 32'h0000_2000;
        tick(); lsb_req = 1'b0;
        tick(); rst = 1'b1;
        #1;
        checks++;
        if (mem_a !== 32'd0 || mem_wr !== 1'b0 || mem_dout !== 8'd0 || lsb_done !== 1'b0 ||
            lsb_rdata !== 32'd0 || ic_data !== 32'd0 || ic_done !== 1'b0) begin
            errors++; $display("FAIL rst_mid_read got a=%h wr=%b d=%h lsd=%b lsdata=%h icdata=%h icd=%b, expected all 0",
                               mem_a, mem_wr, mem_dout, lsb_done, lsb_rdata, ic_data, ic_done);
        end
        @(negedge clk) rst = 1'b0;
        tick();
        t = cyc;
        lsb_req = 1'b1; lsb_addr = 32'h0000_2000; lsb_size = 2'd2;
        ic_req = 1'b1; ic_addr = 32'h0000_1000;
        exp_q.push_back('{"post_rst_lsb", 1'b0, t + 6, 1'b1, 32'hFFC3_B2A1});
        exp_q.push_back('{"post_rst_ic", 1'b1, t + 12, 1'b1, 32'h0010_0513});
        tick(); lsb_req = 1'b0;
        repeat (6) tick();
        ic_req = 1'b0;
        wait_sb();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL post_rst_timeout pending=%0d, expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_exclusive_done();
        repeat (4) tick();
        checks++;
        if (both_cnt != 0) begin errors++; $display("FAIL done_exclusive got %0d overlapping cycles, expected 0", both_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        test_reset();
        test_ic_fetch();
        test_back_to_back();
        test_tie_lsb_first();
        test_store_word();
        test_tie_ic_first();
        test_wrap_half_load();
        test_flush_ic();
        test_flush_store();
        test_reset_mid_read();
        test_exclusive_done();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
